// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, RUN/PAUSE/LAP/IDLE FSM, divider gating
// and a BCD mm:ss.cc count with lap snapshot for the display driver.
module stopwatch_ctrl #(
  parameter int WRAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic        tick,
  output logic        div_en,
  output logic        div_clr,
  output logic [23:0] disp,
  output logic [1:0]  state,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        ss_s1_q, ss_s2_q, ss_d_q;
  logic        lr_s1_q, lr_s2_q, lr_d_q;
  logic        ss_press, lr_press;
  logic [23:0] cnt_q, cnt_d, snap_q;
  logic        div_clr_q, wrap_q, wrap_d;
  logic        run_w, clear_w;
  logic [24:0] inc_w;

  // Digit order low to high: cs_o, cs_t, sec_o, sec_t, min_o, min_t.
  // Returns {carry_out_of_min_t, incremented value}.
  function automatic logic [24:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        c;
    logic [3:0]  lim;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (c) begin
        if (v[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  assign ss_press = ss_s2_q & ~ss_d_q;
  assign lr_press = lr_s2_q & ~lr_d_q;
  assign run_w    = (state_q == RUN) || (state_q == LAP);
  assign clear_w  = (state_q == PAUSE) && lr_press && !ss_press;
  assign inc_w    = bcd_inc(cnt_q);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear_w) begin
      cnt_d = '0;
    end else if (tick && run_w) begin
      if (!inc_w[24]) begin
        cnt_d = inc_w[23:0];
      end else if (WRAP != 0) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ss_s1_q   <= 1'b0;
      ss_s2_q   <= 1'b0;
      ss_d_q    <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      lr_d_q    <= 1'b0;
      cnt_q     <= '0;
      snap_q    <= '0;
      div_clr_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      ss_s1_q   <= btn_ss;
      ss_s2_q   <= ss_s1_q;
      ss_d_q    <= ss_s2_q;
      lr_s1_q   <= btn_lr;
      lr_s2_q   <= lr_s1_q;
      lr_d_q    <= lr_s2_q;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      div_clr_q <= 1'b0;
      // Start/stop has priority; a simultaneous lap/reset press is dropped.
      unique case (state_q)
        IDLE: begin
          if (ss_press) begin
            state_q   <= RUN;
            div_clr_q <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            state_q <= PAUSE;
          end else if (lr_press) begin
            state_q <= LAP;
            snap_q  <= cnt_q;
          end
        end
        LAP: begin
          if (ss_press)      state_q <= PAUSE;
          else if (lr_press) state_q <= RUN;
        end
        PAUSE: begin
          if (ss_press) begin
            state_q <= RUN;
          end else if (lr_press) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            div_clr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state   = state_q;
  assign running = run_w;
  assign div_en  = run_w;
  assign div_clr = div_clr_q;
  assign wrap    = wrap_q;
  assign disp    = (state_q == LAP) ? snap_q : cnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a wrapping and a saturating instance share stimulus;
// a centisecond-count model feeds a scoreboard compared one edge later.
module tb_stopwatch_ctrl;
  localparam int MAXCS = 359999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_ss = 1'b0, btn_lr = 1'b0, tick = 1'b0;
  logic        div_en, div_clr, running, wrap;
  logic [23:0] disp;
  logic [1:0]  state;
  logic        s_div_en, s_div_clr, s_running, s_wrap;
  logic [23:0] s_disp;
  logic [1:0]  s_state;

  stopwatch_ctrl #(.WRAP(1)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr), .tick(tick),
    .div_en(div_en), .div_clr(div_clr), .disp(disp), .state(state),
    .running(running), .wrap(wrap)
  );

  stopwatch_ctrl #(.WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr), .tick(tick),
    .div_en(s_div_en), .div_clr(s_div_clr), .disp(s_disp), .state(s_state),
    .running(s_running), .wrap(s_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [29:0] exp;
    logic [23:0] exp_sat;
  } sb_t;

  sb_t   sb_q[$];
  int    n_chk = 0, n_pass = 0;
  string phase = "reset";

  int          m_cs, m_scs, m_snap, m_ssnap;
  logic [1:0]  m_st;
  logic        m_clr, m_wrap;
  logic [2:0]  m_ss, m_lr;

  function automatic logic [23:0] to_bcd(input int cs);
    int mn, sc, c;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    c  = cs % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_cs = 0; m_scs = 0; m_snap = 0; m_ssnap = 0;
    m_st = 2'd0; m_clr = 1'b0; m_wrap = 1'b0;
    m_ss = 3'b000; m_lr = 3'b000;
  endtask

  task automatic model_edge(input logic tk);
    logic       ssp, lrp, run;
    logic [1:0] nst;
    ssp = m_ss[1] & ~m_ss[0];
    lrp = m_lr[1] & ~m_lr[0];
    run = (m_st == 2'd1) || (m_st == 2'd3);
    nst = m_st;
    m_clr = 1'b0;
    m_wrap = 1'b0;
    case (m_st)
      2'd0: if (ssp) begin nst = 2'd1; m_clr = 1'b1; end
      2'd1: if (ssp) nst = 2'd2;
            else if (lrp) begin nst = 2'd3; m_snap = m_cs; m_ssnap = m_scs; end
      2'd3: if (ssp) nst = 2'd2; else if (lrp) nst = 2'd1;
      default: if (ssp) nst = 2'd1;
               else if (lrp) begin nst = 2'd0; m_snap = 0; m_ssnap = 0; m_clr = 1'b1; end
    endcase
    if (m_st == 2'd2 && lrp && !ssp) begin
      m_cs = 0;
      m_scs = 0;
    end else if (tk && run) begin
      if (m_cs == MAXCS) begin m_cs = 0; m_wrap = 1'b1; end
      else m_cs++;
      if (m_scs < MAXCS) m_scs++;
    end
    m_st = nst;
    m_ss = {btn_ss, m_ss[2], m_ss[1]};
    m_lr = {btn_lr, m_lr[2], m_lr[1]};
  endtask

  function automatic logic [29:0] exp_vec();
    logic run;
    run = (m_st == 2'd1) || (m_st == 2'd3);
    return {to_bcd(m_st == 2'd3 ? m_snap : m_cs), m_st, run, run, m_clr, m_wrap};
  endfunction

  // Drive at the falling edge, predict the next rising edge, compare at the following fall.
  task automatic cycle(input logic tk, input logic ss, input logic lr);
    sb_t e;
    tick = tk;
    btn_ss = ss;
    btn_lr = lr;
    model_edge(tk);
    e.tag = phase;
    e.exp = exp_vec();
    e.exp_sat = to_bcd(m_st == 2'd3 ? m_ssnap : m_scs);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_val({e.tag, ".out"}, {2'b00, disp, state, running, div_en, div_clr, wrap}, {2'b00, e.exp});
    check_val({e.tag, ".sat"}, {7'd0, s_wrap, s_disp}, {8'd0, e.exp_sat});
  endtask

  task automatic press(input logic ss, input logic lr, input logic tk);
    cycle(1'b0, ss, lr);
    cycle(1'b0, ss, lr);
    cycle(tk, ss, lr);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".dut"}, {2'b00, disp, state, running, div_en, div_clr, wrap}, 32'd0);
    check_val({tag, ".sat"}, {2'b00, s_disp, s_state, s_running, s_div_en, s_div_clr, s_wrap}, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    phase = "start";
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("start.not_yet", {30'd0, state}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("start.state", {28'd0, state, div_en, div_clr}, {28'd0, 2'd1, 1'b1, 1'b1});
    cycle(1'b0, 1'b1, 1'b0);
    check_val("start.clr_drop", {31'd0, div_clr}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    phase = "count";
    for (int i = 1; i <= 6000; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (i == 99)  check_val("count.99", {8'd0, disp}, 32'h000099);
      if (i == 100) check_val("count.100", {8'd0, disp}, 32'h000100);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    check_val("count.6000", {8'd0, disp}, 32'h010000);

    phase = "pause";
    press(1'b1, 1'b0, 1'b1);
    check_val("pause.state", {30'd0, state}, 32'd2);
    ticks(5);
    check_val("pause.held", {8'd0, disp}, 32'h010001);
    phase = "clear";
    press(1'b0, 1'b1, 1'b0);
    check_val("clear.idle", {6'd0, disp, state}, 32'd0);
    phase = "idle_lr";
    press(1'b0, 1'b1, 1'b0);
    check_val("idle_lr.state", {30'd0, state}, 32'd0);

    phase = "lap";
    press(1'b1, 1'b0, 1'b0);
    ticks(123);
    check_val("lap.pre", {8'd0, disp}, 32'h000123);
    press(1'b0, 1'b1, 1'b0);
    ticks(50);
    check_val("lap.frozen", {6'd0, disp, state}, {6'd0, 24'h000123, 2'd3});
    press(1'b0, 1'b1, 1'b0);
    check_val("lap.live", {6'd0, disp, state}, {6'd0, 24'h000173, 2'd1});

    phase = "roll";
    force dut.cnt_q = 24'h595999;
    force u_sat.cnt_q = 24'h595999;
    m_cs = MAXCS;
    m_scs = MAXCS;
    cycle(1'b0, 1'b0, 1'b0);
    release dut.cnt_q;
    release u_sat.cnt_q;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_val("roll.wrap", {7'd0, wrap, disp}, {7'd0, 1'b1, 24'h000000});
    check_val("roll.sat", {7'd0, s_wrap, s_disp}, {7'd0, 1'b0, 24'h595999});
    cycle(1'b0, 1'b0, 1'b0);
    check_val("roll.pulse_end", {31'd0, wrap}, 32'd0);
    ticks(3);

    phase = "both";
    press(1'b1, 1'b1, 1'b0);
    check_val("both.pause", {30'd0, state}, 32'd2);

    phase = "async";
    press(1'b1, 1'b0, 1'b0);
    ticks(7);
    #2 reset = 1'b1;
    #1 check_zero("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    phase = "post";
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
